// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory pipeline stage: funct3 size codes
// and the bus-handshake state encoding.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
// Purely combinational; funct3 codes outside B/H/BU/HU behave as a word.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    // Decode size: lane enables, replicated store data, extended load data
    always_comb begin
        shifted      = rdata_i >> {off_i, 3'b000};
        be_o         = 4'hF;
        wdata_o      = wdata_i;
        rdata_o      = shifted;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_LBU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h000000, shifted[7:0]};
            end
            F3_LH: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{shifted[15]}}, shifted[15:0]};
                misaligned_o = off_i[0];
            end
            F3_LHU: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {16'h0000, shifted[15:0]};
                misaligned_o = off_i[0];
            end
            F3_LW:   misaligned_o = (off_i != 2'b00);
            default: misaligned_o = (off_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/data_mem_stage_block.sv
// Memory pipeline stage: launches one req/ack bus transaction per load or
// store, stalls the upstream pipeline while it is outstanding, and returns
// aligned load data with a one-cycle valid pulse.
module data_mem_stage_block
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_memory_data,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_m_e_foward_data,
    output logic [31:0] o_read_data,
    output logic        o_read_valid,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_error,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    // A zero timeout still needs a legal (unused) one-bit counter
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    mem_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, rvalid_q, err_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [3:0]       be_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;

    logic        mem_op, accept, timeout_hit;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_off;
    logic [3:0]  lsa_be;
    logic [31:0] lsa_wdata, lsa_rdata;
    logic        lsa_mis;

    // Stores are steered from the live inputs; loads are extracted with the
    // size/offset captured at launch so the ack cycle does not depend on them.
    assign sel_funct3 = (state_q == S_IDLE) ? i_funct3 : funct3_q;
    assign sel_off    = (state_q == S_IDLE) ? i_alu_result[1:0] : off_q;

    load_store_align u_align (
        .funct3_i     (sel_funct3),
        .off_i        (sel_off),
        .wdata_i      (i_memory_data),
        .rdata_i      (i_bus_rdata),
        .be_o         (lsa_be),
        .wdata_o      (lsa_wdata),
        .rdata_o      (lsa_rdata),
        .misaligned_o (lsa_mis)
    );

    // Launch decision, stall and misalignment are combinational on the op cycle
    always_comb begin
        mem_op       = i_mem_read | i_mem_write;
        accept       = (state_q == S_IDLE) && mem_op && !lsa_mis;
        o_misaligned = (state_q == S_IDLE) && mem_op && lsa_mis;
        o_stall      = accept || (state_q == S_BUSY);
        timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    end

    // Bus handshake FSM with timeout counter and registered results
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_q    <= 1'b1;
                        we_q     <= i_mem_write;
                        addr_q   <= {i_alu_result[31:2], 2'b00};
                        be_q     <= i_mem_write ? lsa_be : 4'hF;
                        wdata_q  <= lsa_wdata;
                        funct3_q <= i_funct3;
                        off_q    <= i_alu_result[1:0];
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_bus_ack) begin
                        req_q    <= 1'b0;
                        cnt_q    <= '0;
                        rvalid_q <= !we_q;
                        if (!we_q) begin
                            rdata_q <= lsa_rdata;
                        end
                        state_q  <= S_DONE;
                    end else if (timeout_hit) begin
                        req_q    <= 1'b0;
                        cnt_q    <= '0;
                        err_q    <= 1'b1;
                        rvalid_q <= !we_q;
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                        state_q  <= S_DONE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_m_e_foward_data = i_alu_result;
    assign o_read_data       = rdata_q;
    assign o_read_valid      = rvalid_q;
    assign o_bus_error       = err_q;
    assign o_bus_req         = req_q;
    assign o_bus_we          = we_q;
    assign o_bus_addr        = addr_q;
    assign o_bus_be          = be_q;
    assign o_bus_wdata       = wdata_q;

endmodule

// File: tb/tb_data_mem_stage_block.sv
// Self-checking bench for data_mem_stage_block (timeout set to 4 cycles).
module tb_data_mem_stage_block;

    logic        clk, rst;
    logic [31:0] alu, mdata, fwd, read_data, bus_addr, bus_wdata, bus_rdata;
    logic        mem_read, mem_write, read_valid, stall, misaligned, bus_error;
    logic        bus_req, bus_we, bus_ack;
    logic [2:0]  funct3;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        load;
    } exp_t;

    typedef struct packed {
        logic [15:0] stall_m;
        logic [15:0] req_m;
        logic [7:0]  done;
        logic        mis;
        logic [31:0] fwd;
        logic        got_bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        rv_after;
    } obs_t;

    exp_t sb_q[$];

    data_mem_stage_block #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_alu_result      (alu),
        .i_memory_data     (mdata),
        .i_mem_read        (mem_read),
        .i_mem_write       (mem_write),
        .i_funct3          (funct3),
        .o_m_e_foward_data (fwd),
        .o_read_data       (read_data),
        .o_read_valid      (read_valid),
        .o_stall           (stall),
        .o_misaligned      (misaligned),
        .o_bus_error       (bus_error),
        .o_bus_req         (bus_req),
        .o_bus_we          (bus_we),
        .o_bus_addr        (bus_addr),
        .o_bus_be          (bus_be),
        .o_bus_wdata       (bus_wdata),
        .i_bus_ack         (bus_ack),
        .i_bus_rdata       (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: byte-by-byte lane model of one aligned access
    function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] data,
                                   input logic [31:0] rword);
        exp_t e;
        int off, sz;
        logic sgn;
        off = int'(addr[1:0]);
        sz  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        sgn = (f3 == 3'b000 || f3 == 3'b001);
        e = '0;
        e.we = wr;
        e.load = !wr;
        e.addr = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = data[8*(i % sz) +: 8];
        if (wr) begin
            for (int i = 0; i < sz; i++) e.be[off + i] = 1'b1;
        end else begin
            e.be = 4'hF;
        end
        for (int i = 0; i < sz; i++) e.rdata[8*i +: 8] = rword[8*(off + i) +: 8];
        if (sz < 4 && sgn) begin
            for (int i = 8*sz; i < 32; i++) e.rdata[i] = e.rdata[8*sz - 1];
        end
        return e;
    endfunction

    // Drives one op and records what the DUT does; ack_at = 0 means never ack
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int ack_at, input logic [31:0] rword, output obs_t o);
        o = '0;
        o.done = 8'hFF;
        mem_read = rd; mem_write = wr; funct3 = f3; alu = addr; mdata = data;
        for (int c = 0; c < 16; c++) begin
            bus_ack   = (ack_at > 0 && c == ack_at);
            bus_rdata = bus_ack ? rword : 32'hDEADBEEF;
            #1;
            if (c == 0) begin o.mis = misaligned; o.fwd = fwd; end
            o.stall_m[c] = stall;
            o.req_m[c]   = bus_req;
            if (bus_req && !o.got_bus) begin
                o.got_bus = 1'b1; o.we = bus_we; o.addr = bus_addr;
                o.be = bus_be; o.wdata = bus_wdata;
            end
            if (c > 0 && !stall) begin
                o.rvalid = read_valid; o.rdata = read_data; o.err = bus_error;
            end
            if (!stall && (c > 0 || misaligned)) begin
                o.done = 8'(c);
                break;
            end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
        o.rv_after = read_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu = 32'h0; mdata = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== 70'h0) begin
            errors++; $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%h wdata=%h required all 0",
                               bus_req, bus_we, bus_addr, bus_be, bus_wdata);
        end
        checks++;
        if ({read_data, read_valid, stall, misaligned, bus_error} !== 36'h0) begin
            errors++; $display("FAIL reset_out: got rdata=%h rv=%b stall=%b mis=%b err=%b required all 0",
                               read_data, read_valid, stall, misaligned, bus_error);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset done");
    endtask

    task automatic test_store_word();
        obs_t o; exp_t e;
        sb_q.push_back(exp_t'{we:1'b1, addr:32'h100, be:4'hF, wdata:32'h11223344, rdata:32'h0, load:1'b0});
        run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'h11223344, 3, 32'h0, o);
        e = sb_q.pop_front();
        $display("SW @100 ack3: be=%h addr=%h wdata=%h stall=%h req=%h done=%0d", o.be, o.addr, o.wdata, o.stall_m, o.req_m, o.done);
        checks++; if ({o.we, o.addr, o.be, o.wdata} !== {e.we, e.addr, e.be, e.wdata}) begin
            errors++; $display("FAIL sw_bus: got we=%b addr=%h be=%h wdata=%h required %b %h %h %h", o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata); end
        checks++; if (o.req_m !== 16'h000E) begin
            errors++; $display("FAIL sw_req_cycles: got %h required 000e", o.req_m); end
        checks++; if (o.stall_m !== 16'h000F) begin
            errors++; $display("FAIL sw_stall_cycles: got %h required 000f", o.stall_m); end
        checks++; if (o.done !== 8'd4 || o.rvalid !== 1'b0 || o.err !== 1'b0) begin
            errors++; $display("FAIL sw_done: got done=%0d rv=%b err=%b required 4 0 0", o.done, o.rvalid, o.err); end
    endtask

    task automatic test_load_byte();
        obs_t o; exp_t e;
        sb_q.push_back(exp_t'{we:1'b0, addr:32'h100, be:4'hF, wdata:32'h0, rdata:32'hFFFFFF80, load:1'b1});
        run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF0000, o);
        e = sb_q.pop_front();
        $display("LB @103: rdata=%h rv=%b addr=%h be=%h", o.rdata, o.rvalid, o.addr, o.be);
        checks++; if (o.rdata !== e.rdata || o.rvalid !== 1'b1) begin
            errors++; $display("FAIL lb_data: got %h rv=%b required %h rv=1", o.rdata, o.rvalid, e.rdata); end
        checks++; if ({o.we, o.addr, o.be} !== {e.we, e.addr, e.be}) begin
            errors++; $display("FAIL lb_bus: got we=%b addr=%h be=%h required %b %h %h", o.we, o.addr, o.be, e.we, e.addr, e.be); end
        checks++; if (o.rv_after !== 1'b0) begin
            errors++; $display("FAIL lb_valid_pulse: got %b required 0", o.rv_after); end
        sb_q.push_back(exp_t'{we:1'b0, addr:32'h100, be:4'hF, wdata:32'h0, rdata:32'h00000080, load:1'b1});
        run_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0000, o);
        e = sb_q.pop_front();
        $display("LBU @103: rdata=%h rv=%b", o.rdata, o.rvalid);
        checks++; if (o.rdata !== e.rdata || o.rvalid !== 1'b1) begin
            errors++; $display("FAIL lbu_data: got %h rv=%b required %h rv=1", o.rdata, o.rvalid, e.rdata); end
    endtask

    task automatic test_halfword_and_misaligned();
        obs_t o; exp_t e;
        sb_q.push_back(exp_t'{we:1'b1, addr:32'h100, be:4'b1100, wdata:32'hABCDABCD, rdata:32'h0, load:1'b0});
        run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1, 32'h0, o);
        e = sb_q.pop_front();
        $display("SH @102: be=%h wdata=%h", o.be, o.wdata);
        checks++; if (o.be !== e.be || o.wdata !== e.wdata) begin
            errors++; $display("FAIL sh_lanes: got be=%h wdata=%h required %h %h", o.be, o.wdata, e.be, e.wdata); end
        run_txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0, o);
        $display("LH @101: mis=%b stall=%h req=%h", o.mis, o.stall_m, o.req_m);
        checks++; if (o.mis !== 1'b1 || o.stall_m !== 16'h0 || o.req_m !== 16'h0 || o.done !== 8'd0) begin
            errors++; $display("FAIL lh_misaligned: got mis=%b stall=%h req=%h done=%0d required 1 0 0 0", o.mis, o.stall_m, o.req_m, o.done); end
        run_txn(1'b1, 1'b0, 3'b111, 32'h102, 32'h0, 1, 32'h0, o);
        $display("f3=111 @102: mis=%b req=%h", o.mis, o.req_m);
        checks++; if (o.mis !== 1'b1 || o.req_m !== 16'h0) begin
            errors++; $display("FAIL unlisted_misaligned: got mis=%b req=%h required 1 0", o.mis, o.req_m); end
        sb_q.push_back(exp_t'{we:1'b0, addr:32'h10C, be:4'hF, wdata:32'h0, rdata:32'h12345678, load:1'b1});
        run_txn(1'b1, 1'b0, 3'b011, 32'h10C, 32'h0, 1, 32'h12345678, o);
        e = sb_q.pop_front();
        $display("f3=011 @10c: rdata=%h mis=%b", o.rdata, o.mis);
        checks++; if (o.rdata !== e.rdata || o.mis !== 1'b0) begin
            errors++; $display("FAIL unlisted_as_word: got %h mis=%b required %h mis=0", o.rdata, o.mis, e.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 1'b1, 3'b010, 32'h40, 32'h55, 0, 32'h0, o);
        $display("SW no ack: err=%b done=%0d stall=%h req=%h", o.err, o.done, o.stall_m, o.req_m);
        checks++; if (o.err !== 1'b1 || o.done !== 8'd5) begin
            errors++; $display("FAIL timeout_error: got err=%b done=%0d required err=1 done=5", o.err, o.done); end
        checks++; if (o.stall_m !== 16'h001F || o.req_m !== 16'h001E) begin
            errors++; $display("FAIL timeout_cycles: got stall=%h req=%h required 001f 001e", o.stall_m, o.req_m); end
        sb_q.push_back(model(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D));
        run_txn(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 4, 32'hCAFEF00D, o);
        $display("LW ack on 4th: err=%b done=%0d rdata=%h", o.err, o.done, o.rdata);
        checks++; if (o.err !== 1'b0 || o.done !== 8'd5 || o.rdata !== sb_q.pop_front().rdata) begin
            errors++; $display("FAIL ack_beats_timeout: got err=%b done=%0d rdata=%h required err=0 done=5 rdata=cafef00d", o.err, o.done, o.rdata); end
    endtask

    task automatic test_reset_mid_txn();
        obs_t o;
        mem_read = 1'b1; funct3 = 3'b010; alu = 32'h200;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        $display("async reset in BUSY: req=%b", bus_req);
        checks++; if (bus_req !== 1'b0) begin
            errors++; $display("FAIL reset_drops_req: got %b required 0", bus_req); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++; if (bus_req !== 1'b0 || read_valid !== 1'b0 || stall !== 1'b0 || bus_error !== 1'b0) begin
            errors++; $display("FAIL stray_ack: got req=%b rv=%b stall=%b err=%b required 0 0 0 0", bus_req, read_valid, stall, bus_error); end
        sb_q.push_back(model(1'b0, 3'b010, 32'h204, 32'h0, 32'h87654321));
        run_txn(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 2, 32'h87654321, o);
        $display("LW after reset: rdata=%h rv=%b done=%0d", o.rdata, o.rvalid, o.done);
        checks++; if (o.rdata !== sb_q.pop_front().rdata || o.rvalid !== 1'b1 || o.done !== 8'd3) begin
            errors++; $display("FAIL lw_after_reset: got rdata=%h rv=%b done=%0d required 87654321 1 3", o.rdata, o.rvalid, o.done); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int k = 0; k < 4; k++) begin
            logic wr;
            wr = k[0];
            run_txn(!wr, wr, 3'b010, 32'h300 + 32'(4*k), 32'hA5A50000 + 32'(k), 1, 32'h5A5A0000 + 32'(k), o);
            $display("b2b %s #%0d: done=%0d stall=%h fwd=%h", wr ? "SW" : "LW", k, o.done, o.stall_m, o.fwd);
            checks++; if (o.done !== 8'd2 || o.stall_m !== 16'h0003) begin
                errors++; $display("FAIL b2b_timing: got done=%0d stall=%h required 2 0003", o.done, o.stall_m); end
            checks++; if (o.fwd !== 32'h300 + 32'(4*k)) begin
                errors++; $display("FAIL b2b_forward: got %h required %h", o.fwd, 32'h300 + 32'(4*k)); end
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [2:0] ops [8];
        ops = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b010};
        for (int k = 0; k < 24; k++) begin
            int sel, lat;
            logic wr;
            logic [2:0] f3;
            logic [31:0] a, d, w;
            sel = int'($urandom_range(7));
            wr  = (sel >= 5);
            f3  = ops[sel];
            a   = $urandom;
            if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
            if (f3 == 3'b010) a[1:0] = 2'b00;
            d   = $urandom;
            w   = $urandom;
            lat = int'($urandom_range(3, 1));
            sb_q.push_back(model(wr, f3, a, d, w));
            run_txn(!wr, wr, f3, a, d, lat, w, o);
            e = sb_q.pop_front();
            $display("rand %0d: %s f3=%b addr=%h be=%h wdata=%h rdata=%h done=%0d", k, wr ? "ST" : "LD", f3, a, o.be, o.wdata, o.rdata, o.done);
            checks++; if ({o.we, o.addr, o.be} !== {e.we, e.addr, e.be} || (wr && o.wdata !== e.wdata)) begin
                errors++; $display("FAIL rand_bus: got we=%b addr=%h be=%h wdata=%h required %b %h %h %h", o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata); end
            checks++; if (o.rvalid !== e.load || (e.load && o.rdata !== e.rdata) || o.done !== 8'(lat + 1)) begin
                errors++; $display("FAIL rand_result: got rv=%b rdata=%h done=%0d required rv=%b rdata=%h done=%0d", o.rvalid, o.rdata, o.done, e.load, e.rdata, lat + 1); end
            checks++; if (o.fwd !== a) begin
                errors++; $display("FAIL rand_forward: got %h required %h", o.fwd, a); end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_halfword_and_misaligned();
        test_timeout();
        test_reset_mid_txn();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
